// File: rtl/pub_domain_arb_pkg.sv
// pub_domain_arb_pkg: shared widths, address type and channel FSM states for the public-domain arbiter
package pub_domain_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int PDA_WIDTH_LEN = 8;
    typedef logic [ADDR_W-1:0] address_d_t;
    typedef logic [PDA_WIDTH_LEN-1:0] pda_len_t;
    typedef enum logic [1:0] {IDLE, WAIT_RDY, XFER, DONE} pda_state_t;
    function automatic logic [1:0] onehot(input logic no);
        return no ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/pub_domain_arb_if.sv
// pub_domain_arb_if: one arbitration channel between two requestors and the public-domain manager
interface pub_domain_arb_if import pub_domain_arb_pkg::*; #(
    parameter int WIDTH_LEN = PDA_WIDTH_LEN
);
    logic [1:0] req;
    address_d_t [1:0] base;
    logic [1:0][WIDTH_LEN-1:0] len;
    logic ready1;
    logic ready2;
    logic beat;
    logic grant1;
    logic grant2;
    logic grant_vld;
    logic grant_no;
    address_d_t grant_base;
    logic xfer_end;
    logic [1:0] ack;
    logic [1:0] err;
    modport master (
        output req, base, len, ready1, ready2, beat,
        input grant1, grant2, grant_vld, grant_no, grant_base, xfer_end, ack, err
    );
    modport slave (
        input req, base, len, ready1, ready2, beat,
        output grant1, grant2, grant_vld, grant_no, grant_base, xfer_end, ack, err
    );
endinterface

// File: rtl/pub_domain_arb_ch.sv
// pub_domain_arb_ch: round-robin arbiter, transfer FSM, beat counter and ready timeout for one channel
module pub_domain_arb_ch import pub_domain_arb_pkg::*; #(
    parameter int WIDTH_LEN = PDA_WIDTH_LEN,
    parameter int TIMEOUT = 256,
    parameter int WIDTH_TO = $clog2(TIMEOUT) + 1
) (
    input logic clock,
    input logic reset,
    pub_domain_arb_if.slave ch
);
    pda_state_t state, state_nx;
    logic no, last, rdy, win, timeout;
    address_d_t base_q;
    logic [WIDTH_LEN-1:0] len_q, cnt;
    logic [WIDTH_TO-1:0] to_cnt;
    logic [1:0] err_q;
    // ties go to whichever requestor was not served last
    assign win = (ch.req == 2'b11) ? ~last : ch.req[1];
    assign rdy = no ? ch.ready2 : ch.ready1;
    assign timeout = !rdy && to_cnt == WIDTH_TO'(TIMEOUT - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = |ch.req ? WAIT_RDY : IDLE;
            WAIT_RDY: state_nx = rdy ? (len_q == '0 ? DONE : XFER) : (timeout ? IDLE : WAIT_RDY);
            XFER:     state_nx = (ch.beat && cnt == WIDTH_LEN'(1)) ? DONE : XFER;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            no     <= 1'b0;
            last   <= 1'b1;
            base_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            to_cnt <= '0;
            err_q  <= '0;
        end else begin
            state  <= state_nx;
            err_q  <= (state == WAIT_RDY && timeout) ? onehot(no) : 2'b00;
            to_cnt <= (state == WAIT_RDY) ? to_cnt + 1'b1 : '0;
            if (state == IDLE && |ch.req) begin
                no     <= win;
                base_q <= ch.base[win];
                len_q  <= ch.len[win];
            end
            if (state == WAIT_RDY && rdy)
                cnt <= len_q;
            else if (state == XFER && ch.beat)
                cnt <= cnt - 1'b1;
            if (state == DONE || (state == WAIT_RDY && timeout))
                last <= no;
        end
    end
    assign ch.grant_vld  = state != IDLE;
    assign ch.grant1     = ch.grant_vld && !no;
    assign ch.grant2     = ch.grant_vld && no;
    assign ch.grant_no   = ch.grant_vld && no;
    assign ch.grant_base = base_q;
    assign ch.xfer_end   = state == DONE;
    assign ch.ack        = (state == DONE) ? onehot(no) : 2'b00;
    assign ch.err        = err_q;
endmodule

// File: rtl/pub_domain_arb.sv
// pub_domain_arb: independent Store and Load arbitration channels in front of the public-domain manager
module pub_domain_arb import pub_domain_arb_pkg::*; #(
    parameter int WIDTH_LEN = PDA_WIDTH_LEN,
    parameter int TIMEOUT = 256,
    parameter int WIDTH_TO = $clog2(TIMEOUT) + 1
) (
    input logic clock,
    input logic reset,
    pub_domain_arb_if.slave st,
    pub_domain_arb_if.slave ld
);
    pub_domain_arb_ch #(.WIDTH_LEN(WIDTH_LEN), .TIMEOUT(TIMEOUT), .WIDTH_TO(WIDTH_TO)) u_st (
        .clock(clock),
        .reset(reset),
        .ch(st)
    );
    pub_domain_arb_ch #(.WIDTH_LEN(WIDTH_LEN), .TIMEOUT(TIMEOUT), .WIDTH_TO(WIDTH_TO)) u_ld (
        .clock(clock),
        .reset(reset),
        .ch(ld)
    );
endmodule

// File: tb/tb_pub_domain_arb.sv
// tb_pub_domain_arb: directed bench with completion scoreboard for both arbitration channels
module tb_pub_domain_arb;
    import pub_domain_arb_pkg::*;

    typedef struct packed {
        logic err;
        logic no;
        address_d_t base;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    exp_t st_q[$];
    exp_t ld_q[$];

    pub_domain_arb_if st ();
    pub_domain_arb_if ld ();

    pub_domain_arb #(.TIMEOUT(8)) dut (
        .clock(clk),
        .reset(rst_n),
        .st(st),
        .ld(ld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] oh(input logic no);
        return no ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] st_outs();
        return {st.grant1, st.grant2, st.grant_vld, st.grant_no, st.xfer_end, st.ack, st.err, st.grant_base};
    endfunction

    function automatic logic [63:0] ld_outs();
        return {ld.grant1, ld.grant2, ld.grant_vld, ld.grant_no, ld.xfer_end, ld.ack, ld.err, ld.grant_base};
    endfunction

    task automatic exp_st(input logic err, input logic no, input address_d_t base);
        exp_t e;
        e.err = err;
        e.no = no;
        e.base = base;
        st_q.push_back(e);
    endtask

    task automatic exp_ld(input logic err, input logic no, input address_d_t base);
        exp_t e;
        e.err = err;
        e.no = no;
        e.base = base;
        ld_q.push_back(e);
    endtask

    // called on the cycle the grant is first visible; ready goes up at once and beats stream continuously
    task automatic st_run(input logic no, input int n);
        st.ready1 = !no;
        st.ready2 = no;
        st.beat = 1'b1;
        for (int i = 0; i <= n; i++) begin
            chk("st_busy", {st.grant1, st.grant2, st.xfer_end}, {!no, no, 1'b0});
            cyc();
        end
        chk("st_done", {st.grant1, st.grant2, st.xfer_end}, {!no, no, 1'b1});
        st.ready1 = 1'b0;
        st.ready2 = 1'b0;
        st.beat = 1'b0;
    endtask

    always @(negedge clk) begin : st_mon
        exp_t e;
        if (st.xfer_end || st.err != 2'b00) begin
            if (st_q.size() == 0)
                chk("st_unexpected", {st.xfer_end, st.err}, '0);
            else begin
                e = st_q.pop_front();
                chk("st_result", {st.xfer_end, st.ack, st.err, st.grant_base},
                    {!e.err, e.err ? 2'b00 : oh(e.no), e.err ? oh(e.no) : 2'b00, e.base});
            end
        end
    end

    always @(negedge clk) begin : ld_mon
        exp_t e;
        if (ld.xfer_end || ld.err != 2'b00) begin
            if (ld_q.size() == 0)
                chk("ld_unexpected", {ld.xfer_end, ld.err}, '0);
            else begin
                e = ld_q.pop_front();
                chk("ld_result", {ld.xfer_end, ld.ack, ld.err, ld.grant_base},
                    {!e.err, e.err ? 2'b00 : oh(e.no), e.err ? oh(e.no) : 2'b00, e.base});
            end
        end
    end

    initial begin
        st.req = '0; st.base = '0; st.len = '0; st.ready1 = 0; st.ready2 = 0; st.beat = 0;
        ld.req = '0; ld.base = '0; ld.len = '0; ld.ready1 = 0; ld.ready2 = 0; ld.beat = 0;
        cyc(3);
        chk("rst_st", st_outs(), '0);
        chk("rst_ld", ld_outs(), '0);
        rst_n = 1'b1;
        cyc();
        // both requestors held: 1, 2, 1 with an idle cycle between grants
        st.req = 2'b11;
        st.base[0] = 32'h200; st.len[0] = 8'd1;
        st.base[1] = 32'h300; st.len[1] = 8'd2;
        exp_st(1'b0, 1'b0, 32'h200);
        exp_st(1'b0, 1'b1, 32'h300);
        exp_st(1'b0, 1'b0, 32'h200);
        cyc();
        chk("t2_first", {st.grant_vld, st.grant1, st.grant_no, st.grant_base}, {1'b1, 1'b1, 1'b0, 32'h200});
        st_run(1'b0, 1);
        cyc();
        chk("t2_gap1", st.grant_vld, '0);
        cyc();
        chk("t2_second", {st.grant_vld, st.grant2, st.grant_no, st.grant_base}, {1'b1, 1'b1, 1'b1, 32'h300});
        st_run(1'b1, 2);
        cyc();
        chk("t2_gap2", st.grant_vld, '0);
        cyc();
        chk("t2_third", {st.grant_vld, st.grant1, st.grant_no, st.grant_base}, {1'b1, 1'b1, 1'b0, 32'h200});
        st_run(1'b0, 1);
        st.req = 2'b00;
        cyc(2);
        chk("t2_idle", st.grant_vld, '0);
        // single request, ready two cycles late, beat during WAIT_RDY ignored
        st.req = 2'b01;
        st.base[0] = 32'h100; st.len[0] = 8'd3;
        exp_st(1'b0, 1'b0, 32'h100);
        cyc();
        chk("t1_grant", {st.grant1, st.grant2, st.grant_no, st.grant_base}, {1'b1, 1'b0, 1'b0, 32'h100});
        st.beat = 1'b1;
        cyc();
        chk("t1_wait", {st.grant1, st.xfer_end}, {1'b1, 1'b0});
        st_run(1'b0, 3);
        st.req = 2'b00;
        cyc();
        chk("t1_drop", {st.grant1, st.grant_vld}, '0);
        // zero-length load from requestor 2
        ld.req = 2'b10;
        ld.base[1] = 32'h400; ld.len[1] = 8'd0;
        exp_ld(1'b0, 1'b1, 32'h400);
        cyc();
        chk("t3_grant", {ld.grant1, ld.grant2, ld.grant_no, ld.xfer_end}, {1'b0, 1'b1, 1'b1, 1'b0});
        cyc();
        chk("t3_wait", {ld.grant2, ld.xfer_end}, {1'b1, 1'b0});
        ld.ready2 = 1'b1;
        cyc();
        chk("t3_done", {ld.grant2, ld.xfer_end, ld.ack}, {1'b1, 1'b1, 2'b10});
        ld.ready2 = 1'b0;
        ld.req = 2'b00;
        cyc();
        chk("t3_idle", ld.grant_vld, '0);
        // timeout: only the wrong ready is asserted
        st.req = 2'b01;
        st.base[0] = 32'h500; st.len[0] = 8'd5;
        st.ready2 = 1'b1;
        exp_st(1'b1, 1'b0, 32'h500);
        cyc();
        chk("t4_grant", {st.grant1, st.grant_no}, {1'b1, 1'b0});
        for (int i = 1; i < 8; i++) begin
            cyc();
            chk("t4_wait", {st.grant1, st.err, st.xfer_end}, {1'b1, 2'b00, 1'b0});
        end
        cyc();
        chk("t4_err", {st.grant1, st.grant_vld, st.err, st.xfer_end}, {1'b0, 1'b0, 2'b01, 1'b0});
        st.req = 2'b00;
        st.ready2 = 1'b0;
        cyc();
        chk("t4_pulse", st.err, '0);
        // overlapping transfers aborted by async reset
        st.req = 2'b01; st.base[0] = 32'h600; st.len[0] = 8'd4;
        ld.req = 2'b01; ld.base[0] = 32'h700; ld.len[0] = 8'd4;
        cyc();
        chk("t5_grants", {st.grant1, ld.grant1}, 2'b11);
        st.ready1 = 1'b1; ld.ready1 = 1'b1; st.beat = 1'b1; ld.beat = 1'b1;
        cyc(2);
        chk("t5_xfer", {st.grant1, ld.grant1, st.xfer_end, ld.xfer_end}, 4'b1100);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_st", st_outs(), '0);
        chk("t5_async_ld", ld_outs(), '0);
        cyc();
        st.req = '0; st.ready1 = 0; st.beat = 0;
        ld.req = '0; ld.ready1 = 0; ld.beat = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t5_after_st", st_outs(), '0);
        chk("t5_after_ld", ld_outs(), '0);
        st.req = 2'b11;
        st.base[0] = 32'h800; st.len[0] = 8'd1; st.base[1] = 32'h900;
        ld.req = 2'b11;
        ld.base[0] = 32'hA00; ld.len[0] = 8'd0;
        exp_st(1'b0, 1'b0, 32'h800);
        exp_ld(1'b0, 1'b0, 32'hA00);
        cyc();
        chk("t5_st_first", {st.grant1, st.grant2, st.grant_no}, {1'b1, 1'b0, 1'b0});
        chk("t5_ld_first", {ld.grant1, ld.grant2, ld.grant_no}, {1'b1, 1'b0, 1'b0});
        ld.req = 2'b00;
        ld.ready1 = 1'b1;
        st_run(1'b0, 1);
        st.req = 2'b00;
        ld.ready1 = 1'b0;
        cyc(3);
        chk("st_q_drained", st_q.size(), '0);
        chk("ld_q_drained", ld_q.size(), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
